// File: rtl/float_add_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor: align, add/normalise, round/assemble.
// Round-to-nearest-even, subnormal support, per-result exception flags; valid/ready on both sides.
module float_add_pipe #(
    parameter int  EXPONENT_WIDTH = 5,
    parameter int  FRACTION_WIDTH = 10,
    localparam int FLOAT_WIDTH    = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] float1,
    input  logic [FLOAT_WIDTH-1:0] float2,
    input  logic                   subtract,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] sum,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_inexact
);

    localparam int E       = EXPONENT_WIDTH;
    localparam int F       = FRACTION_WIDTH;
    localparam int W       = FLOAT_WIDTH;
    localparam int SIG_W   = F + 4;            // hidden, fraction, guard, round, sticky
    localparam int SH_W    = $clog2(SIG_W + 1);
    localparam int ALIGN_W = 2 * F + 6;

    localparam logic [E-1:0] EXP_ONE  = E'(1);
    localparam logic [E:0]   XEXP_ONE = (E + 1)'(1);
    localparam logic [E:0]   XEXP_MAX = {1'b0, {E{1'b1}}};
    localparam logic [W-1:0] QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(F - 1){1'b0}}};

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUBNORMAL,
        CLS_NORMAL,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fclass_e;

    function automatic fclass_e classify(input logic [E-1:0] e, input logic [F-1:0] f);
        if (e == '0) return (f == '0) ? CLS_ZERO : CLS_SUBNORMAL;
        if (e != '1) return CLS_NORMAL;
        if (f == '0) return CLS_INF;
        return f[F-1] ? CLS_QNAN : CLS_SNAN;
    endfunction

    // Handshake: every stage moves together whenever the output slot is free or drained.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- Stage 1: classify, swap, align ----------------
    logic          sign1, sign2;
    logic [E-1:0]  exp1, exp2;
    logic [F-1:0]  frac1, frac2;
    fclass_e       cls1, cls2;
    logic          nan1, nan2, snan1, snan2, inf1, inf2;

    assign sign1 = float1[W-1];
    assign exp1  = float1[W-2:F];
    assign frac1 = float1[F-1:0];
    assign sign2 = float2[W-1] ^ subtract;
    assign exp2  = float2[W-2:F];
    assign frac2 = float2[F-1:0];

    assign cls1  = classify(exp1, frac1);
    assign cls2  = classify(exp2, frac2);
    assign snan1 = (cls1 == CLS_SNAN);
    assign snan2 = (cls2 == CLS_SNAN);
    assign nan1  = snan1 | (cls1 == CLS_QNAN);
    assign nan2  = snan2 | (cls2 == CLS_QNAN);
    assign inf1  = (cls1 == CLS_INF);
    assign inf2  = (cls2 == CLS_INF);

    logic               swap;
    logic               a_sign;
    logic [E-1:0]       a_exp, b_exp, a_exp_eff, b_exp_eff, exp_diff;
    logic [F-1:0]       a_frac, b_frac;
    logic [F:0]         a_sig, b_sig;
    logic [SH_W-1:0]    align_sh;
    logic [ALIGN_W-1:0] align_in, align_out;
    logic [SIG_W-1:0]   a_al, b_al;
    logic               spec, invalid;
    logic [W-1:0]       spec_val;

    always_comb begin
        swap      = {exp2, frac2} > {exp1, frac1};
        a_sign    = swap ? sign2 : sign1;
        a_exp     = swap ? exp2 : exp1;
        a_frac    = swap ? frac2 : frac1;
        b_exp     = swap ? exp1 : exp2;
        b_frac    = swap ? frac1 : frac2;
        a_exp_eff = (a_exp == '0) ? EXP_ONE : a_exp;
        b_exp_eff = (b_exp == '0) ? EXP_ONE : b_exp;
        a_sig     = {a_exp != '0, a_frac};
        b_sig     = {b_exp != '0, b_frac};
        exp_diff  = a_exp_eff - b_exp_eff;

        // Clamping keeps any far-shifted bits inside the sticky window.
        if (int'(exp_diff) > SIG_W) align_sh = SH_W'(SIG_W);
        else                        align_sh = SH_W'(exp_diff);

        align_in  = {b_sig, 2'b00, {(F + 3){1'b0}}};
        align_out = align_in >> align_sh;
        b_al      = {align_out[ALIGN_W-1:F+3], |align_out[F+2:0]};
        a_al      = {a_sig, 3'b000};

        spec      = nan1 | nan2 | inf1 | inf2;
        invalid   = snan1 | snan2 | (inf1 & inf2 & (sign1 != sign2));
        if (nan1 | nan2 | (inf1 & inf2 & (sign1 != sign2))) spec_val = QNAN;
        else if (inf1)                                      spec_val = {sign1, {E{1'b1}}, {F{1'b0}}};
        else                                                spec_val = {sign2, {E{1'b1}}, {F{1'b0}}};
    end

    logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q, s1_invalid_q;
    logic [E-1:0]     s1_exp_q;
    logic [SIG_W-1:0] s1_sig_a_q, s1_sig_b_q;
    logic [W-1:0]     s1_spec_val_q;

    // ---------------- Stage 2: add/subtract and normalise ----------------
    logic [SIG_W:0]   sum_raw;
    logic [E:0]       exp_ext, max_sh, lsh;
    logic [SH_W-1:0]  lz;
    logic             lz_found;
    logic [SIG_W-1:0] s2_sig_d;
    logic [E:0]       s2_exp_d;

    always_comb begin
        exp_ext  = {1'b0, s1_exp_q};
        sum_raw  = s1_sub_q ? ({1'b0, s1_sig_a_q} - {1'b0, s1_sig_b_q})
                            : ({1'b0, s1_sig_a_q} + {1'b0, s1_sig_b_q});
        lz       = SH_W'(SIG_W);
        lz_found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!lz_found && sum_raw[i]) begin
                lz       = SH_W'(SIG_W - 1 - i);
                lz_found = 1'b1;
            end
        end
        max_sh = exp_ext - XEXP_ONE;
        if (int'(lz) > int'(max_sh)) lsh = max_sh;
        else                         lsh = (E + 1)'(lz);

        if (sum_raw[SIG_W]) begin
            s2_sig_d = {sum_raw[SIG_W:2], sum_raw[1] | sum_raw[0]};
            s2_exp_d = exp_ext + XEXP_ONE;
        end else begin
            // Left shift stops at exponent 1; anything still unnormalised is subnormal.
            s2_sig_d = sum_raw[SIG_W-1:0] << lsh;
            s2_exp_d = exp_ext - lsh;
        end
    end

    logic             s2_valid_q, s2_sign_q, s2_sub_q, s2_spec_q, s2_invalid_q;
    logic [E:0]       s2_exp_q;
    logic [SIG_W-1:0] s2_sig_q;
    logic [W-1:0]     s2_spec_val_q;

    // ---------------- Stage 3: round and assemble ----------------
    logic [F:0]   mant, mant_f;
    logic [F+1:0] mant_r;
    logic         g_bit, r_bit, s_bit, rnd_up;
    logic [E:0]   exp_f;
    logic [E-1:0] exp_field;
    logic [W-1:0] sum_d;
    logic         invalid_d, overflow_d, inexact_d;

    always_comb begin
        mant   = s2_sig_q[SIG_W-1:3];
        g_bit  = s2_sig_q[2];
        r_bit  = s2_sig_q[1];
        s_bit  = s2_sig_q[0];
        rnd_up = g_bit & (r_bit | s_bit | mant[0]);
        mant_r = {1'b0, mant} + {{(F + 1){1'b0}}, rnd_up};
        if (mant_r[F+1]) begin
            mant_f = mant_r[F+1:1];
            exp_f  = s2_exp_q + XEXP_ONE;
        end else begin
            mant_f = mant_r[F:0];
            exp_f  = s2_exp_q;
        end
        exp_field = mant_f[F] ? exp_f[E-1:0] : '0;

        sum_d      = {s2_sign_q, exp_field, mant_f[F-1:0]};
        invalid_d  = 1'b0;
        overflow_d = 1'b0;
        inexact_d  = g_bit | r_bit | s_bit;
        if (s2_spec_q) begin
            sum_d     = s2_spec_val_q;
            invalid_d = s2_invalid_q;
            inexact_d = 1'b0;
        end else if (mant_f[F] && (exp_f >= XEXP_MAX)) begin
            sum_d      = {s2_sign_q, {E{1'b1}}, {F{1'b0}}};
            overflow_d = 1'b1;
            inexact_d  = 1'b1;
        end else if (s2_sig_q == '0) begin
            // Exact cancellation yields +0; same-sign zeros keep their sign.
            sum_d = {s2_sign_q & ~s2_sub_q, {(W - 1){1'b0}}};
        end
    end

    logic         out_valid_q, invalid_q, overflow_q, inexact_q;
    logic [W-1:0] sum_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_invalid_q  <= 1'b0;
            s1_exp_q      <= '0;
            s1_sig_a_q    <= '0;
            s1_sig_b_q    <= '0;
            s1_spec_val_q <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_sub_q      <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_invalid_q  <= 1'b0;
            s2_exp_q      <= '0;
            s2_sig_q      <= '0;
            s2_spec_val_q <= '0;
            out_valid_q   <= 1'b0;
            sum_q         <= '0;
            invalid_q     <= 1'b0;
            overflow_q    <= 1'b0;
            inexact_q     <= 1'b0;
        end else if (advance) begin
            s1_valid_q    <= in_valid;
            s1_sign_q     <= a_sign;
            s1_sub_q      <= sign1 ^ sign2;
            s1_spec_q     <= spec;
            s1_invalid_q  <= invalid;
            s1_exp_q      <= a_exp_eff;
            s1_sig_a_q    <= a_al;
            s1_sig_b_q    <= b_al;
            s1_spec_val_q <= spec_val;
            s2_valid_q    <= s1_valid_q;
            s2_sign_q     <= s1_sign_q;
            s2_sub_q      <= s1_sub_q;
            s2_spec_q     <= s1_spec_q;
            s2_invalid_q  <= s1_invalid_q;
            s2_exp_q      <= s2_exp_d;
            s2_sig_q      <= s2_sig_d;
            s2_spec_val_q <= s1_spec_val_q;
            out_valid_q   <= s2_valid_q;
            sum_q         <= sum_d;
            invalid_q     <= invalid_d;
            overflow_q    <= overflow_d;
            inexact_q     <= inexact_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign sum           = sum_q;
    assign flag_invalid  = invalid_q;
    assign flag_overflow = overflow_q;
    assign flag_inexact  = inexact_q;

endmodule
